// File: rtl/inst_loader.sv
// inst_loader
//   Receives a program as a byte stream and writes it into instruction
//   memory as big-endian 32-bit words, starting at word address 0. A load
//   ends normally when the sentinel word 32'hFFFFFFFF has been written.
//   A load ends with an error if memory fills before any sentinel arrives.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start               one-cycle request to begin a load (IDLE/DONE/ERR only)
//   byte_valid          sender is presenting byte_data
//   byte_data           incoming program byte
//   byte_ready          loader accepts a byte this cycle (RECV only)
//   we, waddr, wdata    instruction memory write port (one-cycle strobe)
//   busy                a load is in progress
//   done                sentinel received and written
//   overflow            DEPTH words written without a sentinel
//   word_count          words written in the current load
module inst_loader #(
  parameter int DEPTH  = 200,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  localparam logic [31:0]       SENTINEL  = 32'hFFFF_FFFF;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]  state;
  logic [1:0]  byte_idx;
  // Holds the first three bytes of a word; the fourth byte completes the
  // word straight into wdata so wdata only changes when a write is due.
  logic [23:0] shift_buf;

  assign byte_ready = (state == RECV);
  assign we         = (state == WRITE);
  assign busy       = (state == RECV) || (state == WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_idx   <= 2'd0;
      shift_buf  <= 24'd0;
      waddr      <= '0;
      wdata      <= 32'd0;
      word_count <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= RECV;
            byte_idx   <= 2'd0;
            waddr      <= '0;
            word_count <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
          end
        end

        // start is deliberately not looked at here or in WRITE.
        RECV: begin
          if (byte_valid) begin
            if (byte_idx == 2'd3) begin
              wdata    <= {shift_buf, byte_data};
              byte_idx <= 2'd0;
              state    <= WRITE;
            end else begin
              shift_buf <= {shift_buf[15:0], byte_data};
              byte_idx  <= byte_idx + 2'd1;
            end
          end
        end

        // The write happens during this single cycle; the address and count
        // advance as we leave, so the sentinel is counted like any word.
        WRITE: begin
          waddr      <= waddr + ADDR_W'(1);
          word_count <= word_count + (ADDR_W + 1)'(1);
          if (wdata == SENTINEL) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (waddr == LAST_ADDR) begin
            state    <= ERR;
            overflow <= 1'b1;
          end else begin
            state <= RECV;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader
//   Directed bench for inst_loader with the default DEPTH=200, ADDR_W=8.
//   Every memory write is captured into a log and compared against
//   hand-computed addresses and words.
module tb_inst_loader;

  localparam int DEPTH  = 200;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'd0;
  logic              byte_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;

  int compared   = 0;
  int mismatched = 0;

  logic [ADDR_W-1:0] logAddr[$];
  logic [31:0]       logData[$];
  int  readyInWrite = 0;
  int  longWe       = 0;
  bit  prevWe       = 1'b0;
  bit  vphase       = 1'b1;

  inst_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (we) begin
      logAddr.push_back(waddr);
      logData.push_back(wdata);
      if (byte_ready) readyInWrite++;
      if (prevWe) longWe++;
    end
    prevWe = we;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte until accepted or the cycle bound runs out. With
  // toggle set, byte_valid alternates 1/0 every cycle.
  task automatic applyStimulus(input logic [7:0] b, input bit toggle, input int bound,
                               input bit expectAccept, output bit acc);
    int n = 0;
    acc = 1'b0;
    byte_data = b;
    while (!acc && n < bound) begin
      byte_valid = toggle ? vphase : 1'b1;
      vphase = ~vphase;
      acc = byte_valid && byte_ready;
      @(negedge clk);
      n++;
    end
    byte_valid = 1'b0;
    if (expectAccept) checkOutput("byte_accept", 64'(acc), 64'd1);
  endtask

  task automatic sendWord(input logic [31:0] w, input bit toggle);
    bit acc;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] sh;
      sh = w >> (24 - 8 * k);
      applyStimulus(sh[7:0], toggle, 40, 1'b1, acc);
    end
  endtask

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
  endtask

  initial begin
    bit acc;
    int errs;
    logic [31:0] exp4[4];

    // Reset state
    waitCycles(3);
    checkOutput("reset_outputs",
                64'({byte_ready, we, busy, done, overflow, waddr, wdata, word_count}), 64'd0);
    rst = 1'b0;
    waitCycles(2);
    checkOutput("idle_busy", 64'(busy), 64'd0);

    // Basic load
    clearLog();
    pulseStart();
    checkOutput("recv_ready", 64'(byte_ready), 64'd1);
    sendWord(32'h2001_0014, 1'b0);
    sendWord(32'hFFFF_FFFF, 1'b0);
    waitCycles(2);
    checkOutput("basic_nwrites", 64'(logAddr.size()), 64'd2);
    if (logAddr.size() == 2) begin
      checkOutput("basic_w0", {24'd0, logAddr[0], logData[0]}, {24'd0, 8'd0, 32'h2001_0014});
      checkOutput("basic_w1", {24'd0, logAddr[1], logData[1]}, {24'd0, 8'd1, 32'hFFFF_FFFF});
    end
    checkOutput("basic_done", 64'({done, overflow, busy}), 64'b100);
    checkOutput("basic_count", 64'(word_count), 64'd2);

    // Backpressure: byte_valid toggles every cycle
    exp4[0] = 32'h1122_3344;
    exp4[1] = 32'hA5A5_5A5A;
    exp4[2] = 32'h0000_0001;
    exp4[3] = 32'hFFFF_FFFF;
    clearLog();
    readyInWrite = 0;
    pulseStart();
    for (int i = 0; i < 4; i++) sendWord(exp4[i], 1'b1);
    waitCycles(2);
    checkOutput("bp_nwrites", 64'(logAddr.size()), 64'd4);
    errs = 0;
    for (int i = 0; i < 4 && i < logAddr.size(); i++)
      if (logAddr[i] != ADDR_W'(i) || logData[i] != exp4[i]) errs++;
    checkOutput("bp_writes", 64'(errs), 64'd0);
    checkOutput("bp_ready_in_write", 64'(readyInWrite), 64'd0);
    checkOutput("bp_done_count", 64'({done, word_count}), {54'd0, 1'b1, 9'd4});

    // start pulsed mid-word is ignored
    clearLog();
    pulseStart();
    applyStimulus(8'hDE, 1'b0, 40, 1'b1, acc);
    pulseStart();
    applyStimulus(8'hAD, 1'b0, 40, 1'b1, acc);
    applyStimulus(8'hBE, 1'b0, 40, 1'b1, acc);
    applyStimulus(8'hEF, 1'b0, 40, 1'b1, acc);
    sendWord(32'hFFFF_FFFF, 1'b0);
    waitCycles(2);
    checkOutput("ign_nwrites", 64'(logAddr.size()), 64'd2);
    if (logAddr.size() >= 1)
      checkOutput("ign_w0", {24'd0, logAddr[0], logData[0]}, {24'd0, 8'd0, 32'hDEAD_BEEF});
    checkOutput("ign_done", 64'(done), 64'd1);

    // Reset in the middle of a word
    clearLog();
    pulseStart();
    applyStimulus(8'h12, 1'b0, 40, 1'b1, acc);
    applyStimulus(8'h34, 1'b0, 40, 1'b1, acc);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset",
                   64'({byte_ready, we, busy, done, overflow, waddr, wdata, word_count}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    waitCycles(1);
    pulseStart();
    sendWord(32'hFFFF_FFFF, 1'b0);
    waitCycles(2);
    checkOutput("rst_nwrites", 64'(logAddr.size()), 64'd1);
    if (logAddr.size() >= 1)
      checkOutput("rst_w0", {24'd0, logAddr[0], logData[0]}, {24'd0, 8'd0, 32'hFFFF_FFFF});
    checkOutput("rst_done", 64'({done, word_count}), {54'd0, 1'b1, 9'd1});

    // Reload of 44 words ending in the sentinel
    clearLog();
    pulseStart();
    checkOutput("reload_cleared", 64'({done, waddr, word_count}), 64'd0);
    for (int i = 0; i < 43; i++) sendWord(32'h0C00_0000 + 32'(i), 1'b0);
    sendWord(32'hFFFF_FFFF, 1'b0);
    waitCycles(2);
    checkOutput("reload_nwrites", 64'(logAddr.size()), 64'd44);
    errs = 0;
    for (int i = 0; i < 44 && i < logAddr.size(); i++)
      if (logAddr[i] != ADDR_W'(i) ||
          logData[i] != ((i < 43) ? (32'h0C00_0000 + 32'(i)) : 32'hFFFF_FFFF)) errs++;
    checkOutput("reload_writes", 64'(errs), 64'd0);
    checkOutput("reload_done_count", 64'({done, word_count}), {54'd0, 1'b1, 9'd44});

    // Overflow: DEPTH non-sentinel words
    clearLog();
    pulseStart();
    for (int i = 0; i < DEPTH; i++) sendWord(32'(i), 1'b0);
    waitCycles(2);
    checkOutput("ovf_nwrites", 64'(logAddr.size()), 64'(DEPTH));
    if (logAddr.size() == DEPTH)
      checkOutput("ovf_last", {24'd0, logAddr[DEPTH-1], logData[DEPTH-1]},
                  {24'd0, 8'd199, 32'd199});
    checkOutput("ovf_flags", 64'({overflow, done, busy}), 64'b100);
    checkOutput("ovf_count", 64'(word_count), 64'd200);
    applyStimulus(8'h55, 1'b0, 10, 1'b0, acc);
    checkOutput("ovf_no_accept", 64'(acc), 64'd0);
    checkOutput("ovf_no_extra_write", 64'(logAddr.size()), 64'(DEPTH));
    pulseStart();
    checkOutput("ovf_restart", 64'({overflow, busy, waddr}), {54'd0, 1'b0, 1'b1, 8'd0});

    checkOutput("we_one_cycle", 64'(longWe), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard stop in case a bounded wait is ever miscounted.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 200, meaning instruction memory capacity in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning write address width; DEPTH <= 2**ADDR_W.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a load.
REQ-006 SHALL have port byte_valid, input, 1, byte_data is presented.
REQ-007 SHALL have port byte_data, input, 8, incoming program byte.
REQ-008 SHALL have port byte_ready, output, 1, loader accepts a byte this cycle.
REQ-009 SHALL have port we, output, 1, instruction memory write strobe.
REQ-010 SHALL have port waddr, output, ADDR_W, word write address.
REQ-011 SHALL have port wdata, output, 32, word write data.
REQ-012 SHALL have port busy, output, 1, load in progress.
REQ-013 SHALL have port done, output, 1, sentinel received and written.
REQ-014 SHALL have port overflow, output, 1, DEPTH words written without a sentinel.
REQ-015 SHALL have port word_count, output, ADDR_W+1, words written in the current load.

Function
REQ-016 SHALL implement states IDLE, RECV, WRITE, DONE, ERR.
REQ-017 SHALL leave IDLE, DONE or ERR for RECV on start=1, clearing byte index, waddr, word_count, done and overflow in that transition.
REQ-018 SHALL ignore start while in RECV or WRITE.
REQ-019 SHALL drive byte_ready=1 only in RECV; a byte is accepted on a cycle when byte_valid and byte_ready are both 1.
REQ-020 SHALL assemble words big-endian: the first accepted byte goes to bits 31:24 and the fourth to bits 7:0.
REQ-021 SHALL move to WRITE on the cycle that accepts the fourth byte, then assert we=1 for exactly one cycle in WRITE with wdata equal to the assembled word and waddr equal to the current word address.
REQ-022 SHALL hold byte_ready=0 during WRITE, so each word takes a minimum of 5 cycles.
REQ-023 SHALL increment waddr and word_count on the cycle after each write.
REQ-024 SHALL write the sentinel word 32'hFFFFFFFF to memory like any other word, then enter DONE with done=1.
REQ-025 SHALL enter ERR with overflow=1 if a non-sentinel word is written at address DEPTH-1; no write may ever target an address >= DEPTH.
REQ-026 SHALL hold done and overflow until the next start or reset; done and overflow are never 1 together.
REQ-027 SHALL drive busy=1 in RECV and WRITE only.
REQ-028 SHALL keep we=0 in every state other than WRITE.
REQ-029 SHALL keep waddr and wdata stable while we=0; they are don't-care for memory.
REQ-030 SHALL not accept bytes presented while byte_valid=1 outside RECV; those bytes are the sender's responsibility to hold.
REQ-031 SHALL keep a partially assembled word (1-3 bytes) pending indefinitely while byte_valid=0, with no timeout.

Reset
REQ-032 SHALL, on rst=1 at any time including mid-word or mid-write, go to IDLE immediately and asynchronously.
REQ-033 SHALL, on reset, set byte_ready=0, we=0, busy=0, done=0, overflow=0, waddr=0, wdata=0, word_count=0, and clear the byte index.
REQ-034 SHALL discard any partial word on reset; no write may complete after rst rises.

Verification
REQ-035 SHALL cover a basic load: start, then bytes 20 01 00 14 / FF FF FF FF -> writes (0, 32'h20010014) and (1, 32'hFFFFFFFF); done=1; word_count=2.
REQ-036 SHALL cover backpressure: byte_valid toggling 1/0 every cycle over 3 words + sentinel -> identical writes to the continuous case, with byte_ready=0 on every WRITE cycle.
REQ-037 SHALL cover overflow: 200 non-sentinel words -> last write at waddr=199; overflow=1; done=0; the 201st word's bytes are not accepted.
REQ-038 SHALL cover reset mid-word: two bytes accepted, rst pulse, then start and a full sentinel -> single write (0, 32'hFFFFFFFF); done=1.
REQ-039 SHALL cover a reload: after done, start and load 44 words ending in the sentinel -> waddr restarts at 0; word_count=44; done=1.
REQ-040 SHALL cover start ignored: start pulsed in RECV after one byte -> assembly continues and the byte index is not cleared.
